fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 66 ++++++
 tb/tb_fifo_uart_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO read port and sends them as 8N1-style UART frames
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int S = 8
) (
  input  logic         rd_clk,
  input  logic         rd_rst,
  input  logic         tx_enable,
  input  logic         fifo_empty,
  input  logic [S-1:0] rd_data,
  output logic         rd_en,
  output logic         tx,
  output logic         busy,
  output logic         frame_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = S > 1 ? $clog2(S) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(S - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [S-1:0] sr_q, sr_d;
  logic tx_q, tx_d, rd_en_q, rd_en_d, bit_end;
  always_comb begin
    bit_end = baud_q == BAUD_LAST;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (tx_enable && !fifo_empty) ? FETCH : IDLE;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = START;
      START:   state_d = bit_end ? DATA : START;
      DATA:    state_d = (bit_end && bit_q == BIT_LAST) ? STOP : DATA;
      STOP:    state_d = bit_end ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
    baud_d = (state_q == IDLE || state_d != state_q || bit_end) ? '0 : baud_q + 1'b1;
    bit_d = state_q != DATA ? '0 : bit_end ? bit_q + 1'b1 : bit_q;
    sr_d = state_q == LOAD ? rd_data : (state_q == DATA && bit_end) ? sr_q >> 1 : sr_q;
    // tx and rd_en are registered from the next state so they line up with state_q
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sr_d[0] : 1'b1;
    rd_en_d = state_d == FETCH;
  end
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
    end
  end
  assign tx = tx_q;
  assign rd_en = rd_en_q;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == STOP && bit_end;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed vectors for the FIFO-fed UART transmitter at 4 and 16 clocks per bit
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0;
  logic empty_a, empty_b;
  logic [7:0] rdata_a = '0, rdata_b = '0;
  logic rd_en_a, tx_a, busy_a, fd_a;
  logic rd_en_b, tx_b, busy_b, fd_b;
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0, pops_a = 0, pops_b = 0;
  int n_total = 0, n_pass = 0;
  always #5 clk = ~clk;
  fifo_uart_tx #(.CLKS_PER_BIT(4), .S(8)) dut_a (
    .rd_clk(clk), .rd_rst(rst), .tx_enable(en_a), .fifo_empty(empty_a), .rd_data(rdata_a),
    .rd_en(rd_en_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a));
  fifo_uart_tx #(.CLKS_PER_BIT(16), .S(8)) dut_b (
    .rd_clk(clk), .rd_rst(rst), .tx_enable(en_b), .fifo_empty(empty_b), .rd_data(rdata_b),
    .rd_en(rd_en_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b));
  assign empty_a = wr_a == rd_a;
  assign empty_b = wr_b == rd_b;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  // FIFO models: read data appears the cycle after rd_en
  always @(posedge clk) begin
    if (rd_en_a) begin
      chk("pop_nonempty_a", 32'(wr_a != rd_a), 1);
      rdata_a <= mem_a[rd_a % 16];
      rd_a <= rd_a + 1;
      pops_a <= pops_a + 1;
    end
    if (rd_en_b) begin
      chk("pop_nonempty_b", 32'(wr_b != rd_b), 1);
      rdata_b <= mem_b[rd_b % 16];
      rd_b <= rd_b + 1;
      pops_b <= pops_b + 1;
    end
  end
  task automatic push_a(input logic [7:0] b);
    mem_a[wr_a % 16] = b;
    wr_a++;
  endtask
  task automatic wait_start_a(output int lat, output int idle);
    lat = 0;
    idle = 0;
    while (tx_a === 1'b1 && lat < 60) begin
      lat++;
      if (!busy_a) idle++;
      @(negedge clk);
    end
  endtask
  // f[i] is the i-th bit on the wire: start, d0..d7, stop
  task automatic check_frame_a(input logic [9:0] f, input int ncyc, input int drop_at);
    for (int k = 0; k < ncyc; k++) begin
      if (k == drop_at) en_a = 1'b0;
      chk("frame_a", {tx_a, fd_a, busy_a, rd_en_a}, {f[k/4], k == 39, 1'b1, 1'b0});
      @(negedge clk);
    end
  endtask
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int lat;
    int idle;
  } vec_t;
  vec_t vecs [3];
  initial begin
    int lat, idle;
    logic [9:0] fb;
    vecs[0] = '{8'hA5, 10'b1101001010, 3, 1};
    vecs[1] = '{8'h00, 10'b1000000000, 3, 1};
    vecs[2] = '{8'hFF, 10'b1111111110, 3, 1};
    en_a = 1'b1;
    for (int i = 0; i < 3; i++) push_a(vecs[i].data);
    mem_b[0] = 8'h55;
    wr_b = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_a", {tx_a, busy_a, rd_en_a, fd_a}, 4'b1000);
      chk("reset_b", {tx_b, busy_b, rd_en_b, fd_b}, 4'b1000);
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_start_a(lat, idle);
      chk("start_latency", lat, vecs[i].lat);
      chk("busy_low_gap", idle, vecs[i].idle);
      check_frame_a(vecs[i].frame, 40, -1);
    end
    chk("pops_after_b2b", pops_a, 3);
    for (int i = 0; i < 100; i++) begin
      chk("empty_idle", {rd_en_a, tx_a, busy_a}, 3'b010);
      @(negedge clk);
    end
    chk("pops_after_empty", pops_a, 3);
    push_a(8'h3C);
    push_a(8'h11);
    wait_start_a(lat, idle);
    chk("gate_latency", lat, 3);
    check_frame_a(10'b1001111000, 40, 8);
    for (int i = 0; i < 40; i++) begin
      chk("gated_idle", {rd_en_a, tx_a, busy_a}, 3'b010);
      @(negedge clk);
    end
    chk("pops_gated", pops_a, 4);
    en_a = 1'b1;
    wait_start_a(lat, idle);
    chk("reenable_latency", lat, 3);
    check_frame_a(10'b1000100010, 40, -1);
    chk("pops_reenable", pops_a, 5);
    push_a(8'h5A);
    push_a(8'hC3);
    wait_start_a(lat, idle);
    chk("pre_reset_latency", lat, 3);
    check_frame_a(10'b1010110100, 17, -1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset", {tx_a, busy_a, rd_en_a}, 3'b100);
    rst = 1'b0;
    wait_start_a(lat, idle);
    chk("post_reset_latency", lat, 3);
    check_frame_a(10'b1110000110, 40, -1);
    chk("pops_after_reset", pops_a, 7);
    fb = 10'b1010101010;
    en_b = 1'b1;
    lat = 0;
    while (tx_b === 1'b1 && lat < 60) begin
      lat++;
      @(negedge clk);
    end
    chk("latency_b", lat, 3);
    for (int k = 0; k < 160; k++) begin
      chk("frame_b", {tx_b, fd_b, busy_b}, {fb[k/16], k == 159, 1'b1});
      @(negedge clk);
    end
    chk("after_frame_b", {tx_b, busy_b}, 2'b10);
    chk("pops_b", pops_b, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
